i2c_reg_rw: RTL and testbench

I2C_REG_RW -- requirements
Module: i2c_reg_rw

---
 rtl/i2c_reg_rw.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_reg_rw.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_rw.sv
// i2c_reg_rw
//   Sequences a single register write or read through an external i2c_master.
//   A command is latched on an accepted enable strobe. The first byte sent is
//   always the register index. The second is either the write value or, for
//   a read, a repeated start with rw=1. The last read byte is captured when
//   the master drops busy.
//
//   Optional feature macro: I2C_REG_RW_READ_EN
//     defined   -> rd selects a register read
//     undefined -> every command is a write, rd_data is tied to 0 and no
//                  read-capture logic exists
//
//   Parameters
//     TIMEOUT        max clk cycles spent waiting for any single busy edge
//   Ports
//     clk            clock
//     reset          synchronous, active-low reset
//     chip_addr      7-bit I2C device address
//     reg_addr       register index
//     value          write data
//     rd             1 = register read, 0 = register write
//     enable         command strobe, honoured only while done=1
//     done           idle/ready level
//     rd_data        last read byte
//     ack_error      result flag of the last command (nack or timeout)
//     i2c_busy       from i2c_master
//     i2c_data_rd    from i2c_master
//     i2c_ack_error  from i2c_master
//     i2c_ena        to i2c_master
//     i2c_addr       to i2c_master
//     i2c_rw         to i2c_master
//     i2c_data_wr    to i2c_master
//
//   state  | meaning
//   IDLE   | waiting for a command, master addressed with nothing
//   BYTE0  | register index offered, waiting for master to take it (busy rise)
//   BYTE1  | second byte offered, waiting for its busy rise to drop ena
//   LAST   | waiting for the master to finish (busy fall), capture read data
//   FINISH | one-cycle settle before returning to IDLE
module i2c_reg_rw #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] chip_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] value,
  input  logic       rd,
  input  logic       enable,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_error,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_data_rd,
  input  logic       i2c_ack_error,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYTE0  = 3'd1,
    BYTE1  = 3'd2,
    LAST   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic        busy_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  value_q, value_d;
  logic        ena_q, ena_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  dwr_q, dwr_d;
  logic        ack_q, ack_d;
  logic        is_rd;
  logic        busy_rise, busy_fall, in_wait, timed_out;

`ifdef I2C_REG_RW_READ_EN
  logic       rd_q, rd_d;
  logic [7:0] rd_data_q, rd_data_d;
  assign is_rd   = rd_q;
  assign rd_data = rd_data_q;
`else
  logic unused_rd;
  assign unused_rd = ^{rd, i2c_data_rd};
  assign is_rd     = 1'b0;
  assign rd_data   = 8'h00;
`endif

  assign busy_rise = i2c_busy & ~busy_prev_q;
  assign busy_fall = ~i2c_busy & busy_prev_q;
  assign in_wait   = (state_q == BYTE0) || (state_q == BYTE1) || (state_q == LAST);
  assign timed_out = in_wait && (cnt_q == TO_LIMIT);

  // done also waits on busy so a new command never overlaps a pending stop
  assign done = (state_q == IDLE) && !i2c_busy;

  assign i2c_ena     = ena_q;
  assign i2c_addr    = addr_q;
  assign i2c_rw      = rw_q;
  assign i2c_data_wr = dwr_q;
  assign ack_error   = ack_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_prev_q <= 1'b0;
      cnt_q       <= 16'd0;
      value_q     <= 8'h00;
      ena_q       <= 1'b0;
      addr_q      <= 7'h00;
      rw_q        <= 1'b0;
      dwr_q       <= 8'h00;
      ack_q       <= 1'b0;
`ifdef I2C_REG_RW_READ_EN
      rd_q        <= 1'b0;
      rd_data_q   <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      busy_prev_q <= i2c_busy;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      ena_q       <= ena_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      dwr_q       <= dwr_d;
      ack_q       <= ack_d;
`ifdef I2C_REG_RW_READ_EN
      rd_q        <= rd_d;
      rd_data_q   <= rd_data_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    ena_d   = ena_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    dwr_d   = dwr_q;
    ack_d   = ack_q;
`ifdef I2C_REG_RW_READ_EN
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
`endif

    // sticky nack from BYTE0 through FINISH
    if ((state_q != IDLE) && i2c_ack_error) begin
      ack_d = 1'b1;
    end

    if (timed_out) begin
      ena_d   = 1'b0;
      ack_d   = 1'b1;
      state_d = IDLE;
    end else begin
      // each waiting state reacts to its own busy edge only
      case (state_q)
        IDLE: begin
          if (done && enable) begin
            addr_d  = chip_addr;
            dwr_d   = reg_addr;
            value_d = value;
`ifdef I2C_REG_RW_READ_EN
            rd_d    = rd;
`endif
            ena_d   = 1'b1;
            rw_d    = 1'b0;
            ack_d   = 1'b0;
            state_d = BYTE0;
          end
        end
        BYTE0: begin
          if (busy_rise) begin
            if (is_rd) begin
              rw_d = 1'b1;
            end else begin
              dwr_d = value_q;
            end
            state_d = BYTE1;
          end
        end
        BYTE1: begin
          if (busy_rise) begin
            ena_d   = 1'b0;
            state_d = LAST;
          end
        end
        LAST: begin
          if (busy_fall) begin
`ifdef I2C_REG_RW_READ_EN
            if (rd_q) begin
              rd_data_d = i2c_data_rd;
            end
`endif
            state_d = FINISH;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if ((state_d != state_q) || !in_wait) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2c_reg_rw.sv
// tb_i2c_reg_rw
//   Directed bench for i2c_reg_rw. The i2c_master side is driven by hand,
//   cycle by cycle, and every expected value is written out in the bench.
//   The DUT runs with TIMEOUT=100 so the timeout case stays short.
module tb_i2c_reg_rw;

  logic       clk;
  logic       reset;
  logic [6:0] chip_addr;
  logic [7:0] reg_addr;
  logic [7:0] value;
  logic       rd;
  logic       enable;
  logic       done;
  logic [7:0] rd_data;
  logic       ack_error;
  logic       i2c_busy;
  logic [7:0] i2c_data_rd;
  logic       i2c_ack_error;
  logic       i2c_ena;
  logic [6:0] i2c_addr;
  logic       i2c_rw;
  logic [7:0] i2c_data_wr;

  int n_checks = 0;
  int n_errors = 0;

`ifdef I2C_REG_RW_READ_EN
  localparam logic [7:0] RD_EXP = 8'h80;
`else
  localparam logic [7:0] RD_EXP = 8'h00;
`endif

  i2c_reg_rw #(.TIMEOUT(100)) dut (
    .clk           (clk),
    .reset         (reset),
    .chip_addr     (chip_addr),
    .reg_addr      (reg_addr),
    .value         (value),
    .rd            (rd),
    .enable        (enable),
    .done          (done),
    .rd_data       (rd_data),
    .ack_error     (ack_error),
    .i2c_busy      (i2c_busy),
    .i2c_data_rd   (i2c_data_rd),
    .i2c_ack_error (i2c_ack_error),
    .i2c_ena       (i2c_ena),
    .i2c_addr      (i2c_addr),
    .i2c_rw        (i2c_rw),
    .i2c_data_wr   (i2c_data_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance n rising edges, then settle 1ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [6:0] ca, input logic [7:0] ra, input logic [7:0] va,
                        input logic r);
    chip_addr = ca;
    reg_addr  = ra;
    value     = va;
    rd        = r;
    enable    = 1'b1;
    step(1);
    enable    = 1'b0;
  endtask

  // full command with a hand-driven master: two busy pulses, read byte
  // presented before the final busy fall, optional nack during byte 2
  task automatic run_cmd(input string nm, input logic [6:0] ca, input logic [7:0] ra,
                         input logic [7:0] va, input logic r, input logic [7:0] drd,
                         input logic nack, input logic [7:0] exp_rd);
    logic eff_rd;
`ifdef I2C_REG_RW_READ_EN
    eff_rd = r;
`else
    eff_rd = 1'b0;
`endif
    accept(ca, ra, va, r);
    check({nm, "_acc_ena"},  32'(i2c_ena), 32'd1);
    check({nm, "_acc_addr"}, 32'(i2c_addr), 32'(ca));
    check({nm, "_acc_rw"},   32'(i2c_rw), 32'd0);
    check({nm, "_acc_dwr"},  32'(i2c_data_wr), 32'(ra));
    check({nm, "_acc_done"}, 32'(done), 32'd0);
    check({nm, "_acc_ack"},  32'(ack_error), 32'd0);
    step(2);
    check({nm, "_stable_dwr"}, 32'(i2c_data_wr), 32'(ra));
    i2c_busy = 1'b1;
    step(1);
    check({nm, "_b0_rw"},   32'(i2c_rw), 32'(eff_rd));
    check({nm, "_b0_dwr"},  32'(i2c_data_wr), eff_rd ? 32'(ra) : 32'(va));
    check({nm, "_b0_ena"},  32'(i2c_ena), 32'd1);
    check({nm, "_b0_addr"}, 32'(i2c_addr), 32'(ca));
    step(2);
    i2c_busy = 1'b0;
    step(2);
    check({nm, "_b1_ena_hold"}, 32'(i2c_ena), 32'd1);
    i2c_busy = 1'b1;
    step(1);
    check({nm, "_b1_ena"},  32'(i2c_ena), 32'd0);
    check({nm, "_b1_done"}, 32'(done), 32'd0);
    i2c_data_rd   = drd;
    i2c_ack_error = nack;
    step(1);
    i2c_ack_error = 1'b0;
    step(1);
    i2c_busy = 1'b0;
    step(1);
    check({nm, "_fin_done"}, 32'(done), 32'd0);
    step(1);
    check({nm, "_end_done"}, 32'(done), 32'd1);
    check({nm, "_end_ack"},  32'(ack_error), 32'(nack));
    check({nm, "_end_rd"},   32'(rd_data), 32'(exp_rd));
    check({nm, "_end_ena"},  32'(i2c_ena), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    chip_addr     = 7'h00;
    reg_addr      = 8'h00;
    value         = 8'h00;
    rd            = 1'b0;
    enable        = 1'b0;
    i2c_busy      = 1'b0;
    i2c_data_rd   = 8'h00;
    i2c_ack_error = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);

    check("rst_done", 32'(done), 32'd1);
    check("rst_ena",  32'(i2c_ena), 32'd0);
    check("rst_addr", 32'(i2c_addr), 32'd0);
    check("rst_rw",   32'(i2c_rw), 32'd0);
    check("rst_dwr",  32'(i2c_data_wr), 32'd0);
    check("rst_rd",   32'(rd_data), 32'd0);
    check("rst_ack",  32'(ack_error), 32'd0);

    run_cmd("wr",  7'h39, 8'h41, 8'h10, 1'b0, 8'hCC, 1'b0, 8'h00);
    run_cmd("rd",  7'h50, 8'h9E, 8'h5A, 1'b1, 8'h80, 1'b0, RD_EXP);
    run_cmd("nak", 7'h4C, 8'h98, 8'h03, 1'b0, 8'h11, 1'b1, RD_EXP);
    step(3);
    check("nak_hold_ack", 32'(ack_error), 32'd1);
    run_cmd("clr", 7'h4C, 8'h98, 8'h04, 1'b0, 8'h22, 1'b0, RD_EXP);

    // master never answers: ena must drop exactly 101 cycles after accept
    accept(7'h22, 8'h01, 8'h02, 1'b0);
    check("to_acc_ena", 32'(i2c_ena), 32'd1);
    step(100);
    check("to_c100_ena",  32'(i2c_ena), 32'd1);
    check("to_c100_done", 32'(done), 32'd0);
    check("to_c100_ack",  32'(ack_error), 32'd0);
    step(1);
    check("to_c101_ena",  32'(i2c_ena), 32'd0);
    check("to_c101_ack",  32'(ack_error), 32'd1);
    check("to_c101_done", 32'(done), 32'd1);
    check("to_rd_keep",   32'(rd_data), 32'(RD_EXP));

    // reset while in BYTE1 with busy still high
    accept(7'h39, 8'h41, 8'h10, 1'b0);
    i2c_busy = 1'b1;
    step(1);
    check("mr_b0_dwr", 32'(i2c_data_wr), 32'h10);
    step(2);
    reset = 1'b0;
    step(1);
    check("mr_ena",  32'(i2c_ena), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_addr", 32'(i2c_addr), 32'd0);
    check("mr_rd",   32'(rd_data), 32'd0);
    check("mr_ack",  32'(ack_error), 32'd0);
    reset = 1'b1;
    accept(7'h11, 8'h22, 8'h33, 1'b0);
    check("mr_ign_ena",  32'(i2c_ena), 32'd0);
    check("mr_ign_done", 32'(done), 32'd0);
    check("mr_ign_dwr",  32'(i2c_data_wr), 32'd0);
    step(2);
    check("mr_wait_done", 32'(done), 32'd0);
    i2c_busy = 1'b0;
    #1;
    check("mr_busy_low_done", 32'(done), 32'd1);
    step(2);
    check("mr_after_ena",  32'(i2c_ena), 32'd0);
    check("mr_after_done", 32'(done), 32'd1);

    // controller still usable after the mid-transaction reset
    run_cmd("post", 7'h39, 8'h41, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
